// File: rtl/arm_bus_pkg.sv
// Shared address map, register bit positions and address-region decode
// for the arm data bus and its camera port.
package arm_bus_pkg;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] CAM_DATA_A   = 32'h0000_1000;
  localparam logic [31:0] CAM_STATUS_A = 32'h0000_1004;
  localparam logic [31:0] CAM_CTRL_A   = 32'h0000_1008;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_CAMD,
    REG_CAMS,
    REG_CAMC,
    REG_NONE
  } region_e;

  // Byte-offset bits are dropped before matching, so unaligned addresses
  // alias onto their containing word.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes);
    logic [31:0] wa;
    region_e     r;
    wa = {addr[31:2], 2'b00};
    r  = REG_NONE;
    if ((wa - RAM_BASE) < ram_bytes) r = REG_RAM;
    else if (wa == CAM_DATA_A)       r = REG_CAMD;
    else if (wa == CAM_STATUS_A)     r = REG_CAMS;
    else if (wa == CAM_CTRL_A)       r = REG_CAMC;
    return r;
  endfunction

endpackage

// File: rtl/arm_data_bus_cam_fifo.sv
// Synchronous word FIFO for the camera port. Pop is ignored when empty;
// a push while full is taken only if a pop frees a slot in the same cycle.
module cam_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/arm_data_bus.sv
// Data-memory stage: decodes core loads/stores into a word RAM and a
// memory-mapped camera port that packs pixels into words through a FIFO.
module arm_data_bus
  import arm_bus_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic             read_enable,
  input  logic [31:0]      WriteAddress,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             cam_irq,
  output logic             decode_err
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int          LANES     = 32 / PIX_W;
  localparam int          LANE_W    = $clog2(LANES);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  // Handshake: write_enable/read_enable are single-cycle qualifiers for the
  // address on the same cycle; a store takes priority, and a load's data
  // appears on ReadData after the next rising edge and is held until the
  // next accepted load.

  region_e            region;
  logic               store, load, ctrl_wr, clr_ovf, cam_flush;
  logic               pop, push, ovf_new;
  logic [RAM_AW-1:0]  ram_idx;
  logic [31:0]        ram_q [RAM_WORDS];
  logic [31:0]        status, rd_mux, push_word;
  logic [31:0]        fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;

  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic               err_q, err_d;
  logic               en_q, en_d;
  logic               ovf_q, ovf_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [31:0]        word_q, word_d;

  assign region  = decode_region(WriteAddress, RAM_BYTES);
  assign ram_idx = WriteAddress[RAM_AW+1:2];
  assign store   = write_enable;
  assign load    = read_enable & ~write_enable;
  assign ctrl_wr = store & (region == REG_CAMC);
  assign clr_ovf = ctrl_wr & WriteData[CTRL_CLR_OVF];

  // Dropping enable discards buffered data just like an explicit flush.
  assign cam_flush = ctrl_wr & (WriteData[CTRL_FLUSH] | (en_q & ~WriteData[CTRL_EN]));
  assign pop       = load & (region == REG_CAMD) & ~fifo_empty;

  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    push   = 1'b0;
    if (cam_flush) begin
      lane_d = '0;
    end else if (en_q && pix_valid) begin
      word_d[lane_q*PIX_W +: PIX_W] = pix_data;
      if (lane_q == LANE_W'(LANES - 1)) begin
        push   = 1'b1;
        lane_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  assign push_word = word_d;
  assign ovf_new   = push & fifo_full & ~pop;

  cam_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (cam_flush),
    .din_i   (push_word),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_FULL]             = fifo_full;
    status[ST_OVF]              = ovf_q;
    status[ST_CNT_LSB +: CNT_W] = fifo_count;
    case (region)
      REG_RAM:  rd_mux = ram_q[ram_idx];
      REG_CAMD: rd_mux = pop ? fifo_dout : 32'h0;
      REG_CAMS: rd_mux = status;
      REG_CAMC: rd_mux = 32'(en_q);
      default:  rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = load ? rd_mux : rdata_q;
    irq_d   = en_q & ~fifo_empty;
    err_d   = err_q | ((write_enable | read_enable) & (region == REG_NONE));
    en_d    = ctrl_wr ? WriteData[CTRL_EN] : en_q;
    ovf_d   = (ovf_q & ~clr_ovf) | ovf_new;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      lane_q  <= '0;
      word_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store && region == REG_RAM) ram_q[ram_idx] <= WriteData;
  end

  assign ReadData   = rdata_q;
  assign cam_irq    = irq_q;
  assign decode_err = err_q;

endmodule

// File: tb/tb_arm_data_bus.sv
// Directed bench for arm_data_bus: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_arm_data_bus;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_enable, read_enable, pix_valid;
  logic [31:0] WriteAddress, WriteData, ReadData;
  logic [7:0]  pix_data;
  logic        cam_irq, decode_err;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  arm_data_bus #(
    .RAM_WORDS  (256),
    .FIFO_DEPTH (DEPTH),
    .PIX_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .cam_irq      (cam_irq),
    .decode_err   (decode_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // reference model
  logic [31:0] exp_q[$];
  logic [31:0] m_ram [int];
  logic [7:0]  m_part [4];
  int          m_lane;
  bit          m_en, m_ovf, m_pop, m_cw, m_new_ovf;
  logic [31:0] m_wa;
  logic [31:0] exp_rd;
  logic        exp_irq, exp_err;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = 32'd0;
    s[0]    = (exp_q.size() == 0);
    s[1]    = (exp_q.size() == DEPTH);
    s[2]    = m_ovf;
    s[15:8] = 8'(exp_q.size());
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_lane  = 0;
      m_en    = 1'b0;
      m_ovf   = 1'b0;
      exp_rd  = 32'h0;
      exp_irq = 1'b0;
      exp_err = 1'b0;
    end else begin
      m_wa      = WriteAddress & 32'hFFFF_FFFC;
      m_pop     = 1'b0;
      m_cw      = 1'b0;
      m_new_ovf = 1'b0;
      exp_irq   = m_en && (exp_q.size() != 0);
      if (write_enable) begin
        if (m_wa < 32'd1024) m_ram[int'(m_wa >> 2)] = WriteData;
        else if (m_wa == 32'h1008) m_cw = 1'b1;
        else if (m_wa != 32'h1000 && m_wa != 32'h1004) exp_err = 1'b1;
      end else if (read_enable) begin
        if (m_wa < 32'd1024) exp_rd = m_ram[int'(m_wa >> 2)];
        else if (m_wa == 32'h1000) begin
          if (exp_q.size() > 0) begin
            exp_rd = exp_q[0];
            m_pop  = 1'b1;
          end else begin
            exp_rd = 32'h0;
          end
        end
        else if (m_wa == 32'h1004) exp_rd = model_status();
        else if (m_wa == 32'h1008) exp_rd = {31'b0, m_en};
        else begin
          exp_rd  = 32'h0;
          exp_err = 1'b1;
        end
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_cw && (WriteData[2] || (m_en && !WriteData[0]))) begin
        exp_q.delete();
        m_lane = 0;
      end else if (m_en && pix_valid) begin
        m_part[m_lane] = pix_data;
        m_lane++;
        if (m_lane == 4) begin
          m_lane = 0;
          if (exp_q.size() < DEPTH) exp_q.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
          else m_new_ovf = 1'b1;
        end
      end
      m_ovf = (m_ovf && !(m_cw && WriteData[1])) || m_new_ovf;
      if (m_cw) m_en = WriteData[0];
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      check("ReadData", ReadData, exp_rd);
      check("cam_irq", 32'(cam_irq), 32'(exp_irq));
      check("decode_err", 32'(decode_err), 32'(exp_err));
    end
  end

  // drivers
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    write_enable = 1'b1;
    WriteAddress = a;
    WriteData    = d;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] rd);
    read_enable  = 1'b1;
    WriteAddress = a;
    @(negedge clk);
    read_enable  = 1'b0;
    rd = ReadData;
  endtask

  task automatic pixel(input logic [7:0] p);
    pix_valid = 1'b1;
    pix_data  = p;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] rd;

  initial begin
    write_enable = 1'b0;
    read_enable  = 1'b0;
    pix_valid    = 1'b0;
    pix_data     = 8'h0;
    WriteAddress = 32'h0;
    WriteData    = 32'h0;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    idle(2);
    check("reset_readdata", ReadData, 32'h0);
    check("reset_irq", 32'(cam_irq), 32'h0);
    check("reset_err", 32'(decode_err), 32'h0);
    rst_n   = 1'b1;
    run_cmp = 1'b1;
    idle(2);
    load(32'h1004, rd);
    check("reset_status", rd, 32'h0000_0001);

    // RAM
    store(32'h10, 32'hDEADBEEF);
    load(32'h10, rd);
    check("ram_load_10", rd, 32'hDEADBEEF);
    store(32'h14, 32'h1);
    load(32'h14, rd);
    check("ram_load_14", rd, 32'h1);
    idle(2);
    check("ram_hold", ReadData, 32'h1);
    write_enable = 1'b1;
    read_enable  = 1'b1;
    WriteAddress = 32'h10;
    WriteData    = 32'h1234_5678;
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check("store_wins_hold", ReadData, 32'h1);
    load(32'h10, rd);
    check("store_wins_data", rd, 32'h1234_5678);

    // packing
    store(32'h1008, 32'h1);
    pixel(8'h11); pixel(8'h22); pixel(8'h33); pixel(8'h44);
    load(32'h1004, rd);
    check("pack_status", rd, 32'h0000_0100);
    check("pack_irq", 32'(cam_irq), 32'h1);
    load(32'h1000, rd);
    check("pack_data", rd, 32'h4433_2211);
    load(32'h1004, rd);
    check("pack_empty", rd, 32'h0000_0001);
    check("pack_irq_clear", 32'(cam_irq), 32'h0);
    load(32'h1000, rd);
    check("empty_pop", rd, 32'h0);

    // overflow
    for (int i = 0; i < 4 * (DEPTH + 1); i++) pixel(8'(i));
    load(32'h1004, rd);
    check("ovf_status", rd, 32'h0000_1006);
    load(32'h1000, rd);
    check("ovf_first_word", rd, 32'h0302_0100);
    store(32'h1008, 32'h3);
    load(32'h1004, rd);
    check("clr_ovf_status", rd, 32'h0000_0F00);

    // full with concurrent pop and push
    pixel(8'h44); pixel(8'h45); pixel(8'h46); pixel(8'h47);
    load(32'h1004, rd);
    check("refill_status", rd, 32'h0000_1002);
    pixel(8'h50); pixel(8'h51); pixel(8'h52);
    pix_valid    = 1'b1;
    pix_data     = 8'h53;
    read_enable  = 1'b1;
    WriteAddress = 32'h1000;
    @(negedge clk);
    pix_valid    = 1'b0;
    read_enable  = 1'b0;
    check("popush_data", ReadData, 32'h0706_0504);
    load(32'h1004, rd);
    check("popush_status", rd, 32'h0000_1002);
    for (int i = 0; i < DEPTH; i++) begin
      load(32'h1000, rd);
      if (i == 0)  check("drain_first", rd, 32'h0B0A_0908);
      if (i == 14) check("drain_refill", rd, 32'h4746_4544);
      if (i == 15) check("drain_last", rd, 32'h5352_5150);
    end
    load(32'h1004, rd);
    check("drain_status", rd, 32'h0000_0001);

    // flush and disable
    for (int i = 0; i < 14; i++) pixel(8'(8'h60 + i));
    store(32'h1008, 32'h5);
    load(32'h1004, rd);
    check("flush_status", rd, 32'h0000_0001);
    pixel(8'hA0); pixel(8'hA1); pixel(8'hA2); pixel(8'hA3);
    load(32'h1000, rd);
    check("flush_repack", rd, 32'hA3A2_A1A0);
    pixel(8'h01); pixel(8'h02);
    store(32'h1008, 32'h0);
    pixel(8'hEE);
    store(32'h1008, 32'h1);
    pixel(8'hB0); pixel(8'hB1); pixel(8'hB2); pixel(8'hB3);
    load(32'h1000, rd);
    check("disable_repack", rd, 32'hB3B2_B1B0);

    // unmapped access and mid-stream reset
    load(32'h2000, rd);
    check("unmapped_data", rd, 32'h0);
    check("unmapped_err", 32'(decode_err), 32'h1);
    pixel(8'h70); pixel(8'h71); pixel(8'h72); pixel(8'h73);
    pixel(8'h74); pixel(8'h75);
    load(32'h1004, rd);
    check("pre_reset_status", rd, 32'h0000_0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_data", ReadData, 32'h0);
    check("async_reset_irq", 32'(cam_irq), 32'h0);
    check("async_reset_err", 32'(decode_err), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    store(32'h1008, 32'h1);
    pixel(8'hC0); pixel(8'hC1); pixel(8'hC2); pixel(8'hC3);
    load(32'h1000, rd);
    check("post_reset_pack", rd, 32'hC3C2_C1C0);
    idle(2);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
